split_rr: RTL and testbench

//  Parametrised round-robin stream splitter for the flow library: a single nd-qualified

---
 rtl/split_rr_pkg.sv | 15 +
 rtl/split_fifo.sv | 65 ++++++
 rtl/split_rr.sv | 109 ++++++++++
 tb/tb_split_rr.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/split_rr_pkg.sv
// Shared types and helpers for the round-robin stream splitter.
package split_rr_pkg;

    // Distribution mode of the write side.
    typedef enum logic {
        MODE_DEINTERLEAVE = 1'b0,
        MODE_BROADCAST    = 1'b1
    } mode_e;

    // Counter width for a modulus n; a single-state counter still gets one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/split_fifo.sv
// Per-channel synchronous FIFO with a registered data/nd output stage.
// A pop moves the head word into dout and pulses dout_nd on the next cycle;
// dout holds its last value otherwise.
module split_fifo #(
    parameter int WDTH      = 32,
    parameter int DEPTH     = 8,
    parameter int LOG_DEPTH = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  logic [WDTH-1:0] din,
    input  logic            pop_req,
    output logic            full,
    output logic            empty,
    output logic [WDTH-1:0] dout,
    output logic            dout_nd
);

    logic [WDTH-1:0]    mem [DEPTH];
    logic [LOG_DEPTH:0] wr_ptr;
    logic [LOG_DEPTH:0] rd_ptr;
    logic               pop;
    logic               wr_en;

    // The extra pointer MSB distinguishes full from empty when the indices match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[LOG_DEPTH] != rd_ptr[LOG_DEPTH]) &&
                   (wr_ptr[LOG_DEPTH-1:0] == rd_ptr[LOG_DEPTH-1:0]);
    assign pop   = pop_req && !empty;
    // A push into a full FIFO is still taken when a pop frees the slot in the same cycle.
    assign wr_en = push && (!full || pop);

    // Read/write pointer update.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values, independent of statement order.
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write.
    always_ff @(posedge clk) begin
        // NOTE: the storage array is deliberately not reset; the pointers alone
        // define which entries are valid, and a reset-free array maps to RAM.
        if (wr_en) mem[wr_ptr[LOG_DEPTH-1:0]] <= din;
    end

    // Registered output stage: one-cycle nd pulse per popped word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dout    <= '0;
            dout_nd <= 1'b0;
        end else begin
            dout_nd <= pop;
            if (pop) dout <= mem[rd_ptr[LOG_DEPTH-1:0]];
        end
    end

endmodule

// File: rtl/split_rr.sv
// Round-robin stream splitter: distributes an nd-qualified stream over N_CHAN
// channels, GROUP samples per channel, or broadcasts every sample to all channels.
// Each channel is buffered by its own FIFO and drained under out_ready.
module split_rr
    import split_rr_pkg::*;
#(
    parameter int WDTH      = 32,
    parameter int N_CHAN    = 2,
    parameter int GROUP     = 1,
    parameter int DEPTH     = 8,
    parameter int LOG_DEPTH = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   mode,
    input  logic                   sync,
    input  logic [WDTH-1:0]        in_data,
    input  logic                   in_nd,
    input  logic [N_CHAN-1:0]      out_ready,
    output logic [N_CHAN*WDTH-1:0] out_data,
    output logic [N_CHAN-1:0]      out_nd,
    output logic                   error
);

    localparam int CW = cnt_width(N_CHAN);
    localparam int GW = cnt_width(GROUP);
    localparam logic [CW-1:0] CHAN_LAST = CW'(N_CHAN - 1);
    localparam logic [GW-1:0] GRP_LAST  = GW'(GROUP - 1);

    logic [CW-1:0]     chan_q;
    logic [CW-1:0]     chan_d;
    logic [CW-1:0]     wr_chan;
    logic [GW-1:0]     grp_q;
    logic [GW-1:0]     grp_d;
    logic [GW-1:0]     wr_grp;
    mode_e             mode_q;
    mode_e             mode_eff;
    logic              frame_start;
    logic [N_CHAN-1:0] push;
    logic [N_CHAN-1:0] drop;
    logic [N_CHAN-1:0] fifo_full;
    logic [N_CHAN-1:0] fifo_empty;

    // Write position, mode selection and counter advance for this cycle.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        wr_chan     = sync ? '0 : chan_q;
        wr_grp      = sync ? '0 : grp_q;
        frame_start = (wr_chan == '0) && (wr_grp == '0);
        // A new mode only takes effect at a frame boundary, keeping frames whole.
        mode_eff    = frame_start ? mode_e'(mode) : mode_q;
        chan_d      = wr_chan;
        grp_d       = wr_grp;
        if (in_nd) begin
            // Counters advance in both modes (and on drops) so alignment is never lost.
            if (wr_grp == GRP_LAST) begin
                grp_d  = '0;
                chan_d = (wr_chan == CHAN_LAST) ? '0 : wr_chan + 1'b1;
            end else begin
                grp_d  = wr_grp + 1'b1;
            end
        end
    end

    // Write decode and overflow detection per channel.
    always_comb begin
        push = '0;
        drop = '0;
        for (int i = 0; i < N_CHAN; i++) begin
            push[i] = in_nd && ((mode_eff == MODE_BROADCAST) || (wr_chan == CW'(i)));
            drop[i] = push[i] && fifo_full[i] && !(out_ready[i] && !fifo_empty[i]);
        end
    end

    // Position counters, mode latch and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            chan_q <= '0;
            grp_q  <= '0;
            mode_q <= mode_e'(mode);
            error  <= 1'b0;
        end else begin
            chan_q <= chan_d;
            grp_q  <= grp_d;
            mode_q <= mode_eff;
            if (|drop) error <= 1'b1;
        end
    end

    for (genvar c = 0; c < N_CHAN; c++) begin : g_chan
        split_fifo #(
            .WDTH      (WDTH),
            .DEPTH     (DEPTH),
            .LOG_DEPTH (LOG_DEPTH)
        ) u_fifo (
            .clk     (clk),
            .rst_n   (rst_n),
            .push    (push[c]),
            .din     (in_data),
            .pop_req (out_ready[c]),
            .full    (fifo_full[c]),
            .empty   (fifo_empty[c]),
            .dout    (out_data[c*WDTH +: WDTH]),
            .dout_nd (out_nd[c])
        );
    end

endmodule

// File: tb/tb_split_rr.sv
// Directed, scoreboard-based bench for split_rr. Three instances cover the
// parameter sets needed: A (2 ch, GROUP 1, DEPTH 8), B (3 ch, GROUP 2),
// C (2 ch, DEPTH 4). Inputs are shared; sel picks the instance being scored.
module tb_split_rr;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        mode;
    logic        sync;
    logic        in_nd;
    logic [31:0] in_data;
    logic [1:0]  rdy_a;
    logic [2:0]  rdy_b;
    logic [1:0]  rdy_c;
    logic [63:0] data_a;
    logic [95:0] data_b;
    logic [63:0] data_c;
    logic [1:0]  nd_a;
    logic [2:0]  nd_b;
    logic [1:0]  nd_c;
    logic        err_a;
    logic        err_b;
    logic        err_c;

    split_rr #(.WDTH(32), .N_CHAN(2), .GROUP(1), .DEPTH(8), .LOG_DEPTH(3)) dut_a (
        .clk(clk), .rst_n(rst_n), .mode(mode), .sync(sync), .in_data(in_data),
        .in_nd(in_nd), .out_ready(rdy_a), .out_data(data_a), .out_nd(nd_a), .error(err_a));

    split_rr #(.WDTH(32), .N_CHAN(3), .GROUP(2), .DEPTH(8), .LOG_DEPTH(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .mode(mode), .sync(sync), .in_data(in_data),
        .in_nd(in_nd), .out_ready(rdy_b), .out_data(data_b), .out_nd(nd_b), .error(err_b));

    split_rr #(.WDTH(32), .N_CHAN(2), .GROUP(1), .DEPTH(4), .LOG_DEPTH(2)) dut_c (
        .clk(clk), .rst_n(rst_n), .mode(mode), .sync(sync), .in_data(in_data),
        .in_nd(in_nd), .out_ready(rdy_c), .out_data(data_c), .out_nd(nd_c), .error(err_c));

    typedef struct {
        logic [31:0] data;
        int          cyc;   // expected edge count of arrival, -1 = any time
    } exp_t;

    exp_t exp_q [3][$];
    int   checks  = 0;
    int   errors  = 0;
    int   cyc_cnt = 0;
    int   sel     = 0;
    exp_t mon_e;

    logic [2:0]  mon_nd;
    logic [31:0] mon_data [3];

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Route the selected instance's outputs to the monitor.
    always_comb begin
        mon_nd = '0;
        for (int c = 0; c < 3; c++) mon_data[c] = '0;
        case (sel)
            0: begin
                mon_nd      = {1'b0, nd_a};
                mon_data[0] = data_a[31:0];
                mon_data[1] = data_a[63:32];
            end
            1: begin
                mon_nd      = nd_b;
                mon_data[0] = data_b[31:0];
                mon_data[1] = data_b[63:32];
                mon_data[2] = data_b[95:64];
            end
            default: begin
                mon_nd      = {1'b0, nd_c};
                mon_data[0] = data_c[31:0];
                mon_data[1] = data_c[63:32];
            end
        endcase
    end

    // Scoreboard: every output pulse must match the head of its channel queue.
    always @(negedge clk) begin
        for (int c = 0; c < 3; c++) begin
            if (mon_nd[c] === 1'b1) begin
                check($sformatf("ch%0d_expected_any", c), 32'(exp_q[c].size() != 0), 32'd1);
                if (exp_q[c].size() != 0) begin
                    mon_e = exp_q[c].pop_front();
                    check($sformatf("ch%0d_data", c), mon_data[c], mon_e.data);
                    if (mon_e.cyc >= 0)
                        check($sformatf("ch%0d_latency", c), cyc_cnt, mon_e.cyc);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Drive one sample; mask names the channels that must receive it.
    task automatic send(input logic [31:0] d, input logic [2:0] mask,
                        input bit timed, input bit with_sync);
        for (int c = 0; c < 3; c++)
            if (mask[c]) exp_q[c].push_back('{data: d, cyc: (timed ? cyc_cnt + 2 : -1)});
        in_data = d;
        in_nd   = 1'b1;
        sync    = with_sync;
        tick();
        in_nd   = 1'b0;
        sync    = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) exp_q[c].delete();
    endtask

    // Wait (bounded) for all expected outputs, then require empty queues.
    task automatic drain(input string tag);
        int n = 0;
        while (n < 60 && (exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) != 0) begin
            tick();
            n++;
        end
        idle(3);
        for (int c = 0; c < 3; c++)
            check($sformatf("%s_ch%0d_left", tag, c), 32'(exp_q[c].size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] m;
        mode    = 1'b0;
        sync    = 1'b0;
        in_nd   = 1'b0;
        in_data = '0;
        rdy_a   = 2'b11;
        rdy_b   = 3'b111;
        rdy_c   = 2'b11;
        rst_n   = 1'b0;
        tick();
        do_reset();

        // Reset state.
        sel = 0;
        check("rst_nd", 32'(nd_a), 32'd0);
        check("rst_data0", data_a[31:0], 32'd0);
        check("rst_data1", data_a[63:32], 32'd0);
        check("rst_error", 32'(err_a), 32'd0);

        // 1: two channels, alternate, one-cycle latency.
        for (int i = 1; i <= 8; i++) send(32'(i), (i % 2 == 1) ? 3'b001 : 3'b010, 1'b1, 1'b0);
        drain("t1");
        check("t1_hold0", data_a[31:0], 32'd7);
        check("t1_hold1", data_a[63:32], 32'd8);
        check("t1_nd_idle", 32'(nd_a), 32'd0);
        check("t1_error", 32'(err_a), 32'd0);

        // 2: three channels, groups of two.
        do_reset();
        sel = 1;
        for (int i = 1; i <= 12; i++) begin
            m = 3'(1 << (((i - 1) / 2) % 3));
            send(32'(i), m, 1'b1, 1'b0);
        end
        drain("t2");
        check("t2_error", 32'(err_b), 32'd0);

        // 4: broadcast requested mid-frame, effective at next boundary.
        do_reset();
        sel = 0;
        send(32'd1, 3'b001, 1'b1, 1'b0);
        send(32'd2, 3'b010, 1'b1, 1'b0);
        send(32'd3, 3'b001, 1'b1, 1'b0);
        mode = 1'b1;
        send(32'd4, 3'b010, 1'b1, 1'b0);
        send(32'd5, 3'b011, 1'b1, 1'b0);
        send(32'd6, 3'b011, 1'b1, 1'b0);
        mode = 1'b0;
        send(32'd7, 3'b001, 1'b1, 1'b0);
        send(32'd8, 3'b010, 1'b1, 1'b0);
        drain("t4");

        // 5: sync with and without a sample.
        do_reset();
        send(32'd1, 3'b001, 1'b1, 1'b0);
        send(32'd2, 3'b010, 1'b1, 1'b0);
        send(32'd3, 3'b001, 1'b1, 1'b0);
        send(32'd5, 3'b001, 1'b1, 1'b1);
        send(32'd6, 3'b010, 1'b1, 1'b0);
        send(32'd7, 3'b001, 1'b1, 1'b0);
        sync = 1'b1;
        tick();
        sync = 1'b0;
        send(32'd8, 3'b001, 1'b1, 1'b0);
        send(32'd9, 3'b010, 1'b1, 1'b0);
        drain("t5");

        // 3: DEPTH 4, channel 1 stalled -> overflow on 10 and 12.
        do_reset();
        sel   = 2;
        rdy_c = 2'b01;
        for (int i = 1; i <= 12; i++) begin
            if (i % 2 == 1)  m = 3'b001;
            else if (i <= 8) m = 3'b010;
            else             m = 3'b000;
            send(32'(i), m, 1'b0, 1'b0);
            if (i == 9) check("t3_error_before", 32'(err_c), 32'd0);
        end
        check("t3_error_set", 32'(err_c), 32'd1);
        send(32'd13, 3'b001, 1'b0, 1'b0);
        rdy_c = 2'b11;
        send(32'd14, 3'b010, 1'b0, 1'b0);
        drain("t3");
        check("t3_error_sticky", 32'(err_c), 32'd1);
        check("t3_hold1", data_c[63:32], 32'd14);

        // 6: reset with samples buffered discards them.
        rdy_c = 2'b00;
        send(32'd20, 3'b000, 1'b0, 1'b0);
        send(32'd21, 3'b000, 1'b0, 1'b0);
        send(32'd22, 3'b000, 1'b0, 1'b0);
        do_reset();
        check("t6_nd", 32'(nd_c), 32'd0);
        check("t6_data0", data_c[31:0], 32'd0);
        check("t6_data1", data_c[63:32], 32'd0);
        check("t6_error", 32'(err_c), 32'd0);
        rdy_c = 2'b11;
        idle(6);
        send(32'd30, 3'b001, 1'b1, 1'b0);
        drain("t6");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
